stk_ctl: RTL and testbench

Return-address stack controller for the CPU core. Sits between the instruction decoder (CALL/RET requests) and the 4-entry, 12-bit return-address stack storage. The storage writes on `push` at the clock edge and registers its read output `stko` from the slot addressed by `sp` one edge later. `stk_ctl` owns the stack depth counter and drives `push`/`sp`/`pcx`. It returns popped addresses to the PC logic and flags overflow and underflow.

---
 rtl/stk_pkg.sv | 14 +
 rtl/stk_ctl_if.sv | 35 +++
 rtl/stk_ctl.sv | 98 +++++++++
 tb/tb_stk_ctl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/stk_pkg.sv
// Shared constants and FSM state type for the return-address stack controller.
package stk_pkg;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int SPW   = 2;

  // Count value meaning "all slots in use", sized to the depth counter.
  localparam logic [SPW:0] CNT_FULL = (SPW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    RWAIT
  } stk_state_t;
endpackage

// File: rtl/stk_ctl_if.sv
// Decoder/storage-facing signal bundle of the return-address stack controller.
interface stk_ctl_if;
  import stk_pkg::*;

  logic             call;
  logic             ret;
  logic             flush;
  logic             err_clr;
  logic [AW-1:0]    pc;
  logic [AW-1:0]    stko;
  logic             push;
  logic [SPW-1:0]   sp;
  logic [AW-1:0]    pcx;
  logic             busy;
  logic             call_ack;
  logic             ret_valid;
  logic [AW-1:0]    ret_addr;
  logic [SPW:0]     depth;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;

  modport master (
    output call, ret, flush, err_clr, pc, stko,
    input  push, sp, pcx, busy, call_ack, ret_valid, ret_addr,
    input  depth, full, empty, ovf, udf
  );

  modport slave (
    input  call, ret, flush, err_clr, pc, stko,
    output push, sp, pcx, busy, call_ack, ret_valid, ret_addr,
    output depth, full, empty, ovf, udf
  );
endinterface

// File: rtl/stk_ctl.sv
// Return-address stack controller: owns the depth counter, drives the storage
// write strobe/pointer and hands popped addresses back to the PC logic.
module stk_ctl
  import stk_pkg::*;
(
  input  logic     Clk,
  input  logic     Rst,
  stk_ctl_if.slave bus
);

  stk_state_t     r_state;
  logic [SPW:0]   r_cnt;
  logic           r_call_ack;
  logic           r_ret_valid;
  logic [AW-1:0]  r_ret_addr;
  logic           r_ovf;
  logic           r_udf;

  logic           w_idle;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic [SPW:0]   w_cnt_m1;
  logic           w_ovf_set;
  logic           w_udf_set;

  assign w_idle   = (r_state == IDLE);
  assign w_full   = (r_cnt == CNT_FULL);
  assign w_empty  = (r_cnt == '0);
  assign w_cnt_m1 = r_cnt - 1'b1;

  // Flush and reset both suppress the write so no slot is touched while clearing.
  assign w_push    = w_idle && bus.call && !w_full && !bus.flush && !Rst;
  assign w_ovf_set = w_idle && bus.call && w_full && !bus.flush;
  assign w_udf_set = w_idle && !bus.call && bus.ret && w_empty && !bus.flush;

  assign bus.push      = w_push;
  assign bus.sp        = w_push ? r_cnt[SPW-1:0] : w_cnt_m1[SPW-1:0];
  assign bus.pcx       = bus.pc + 1'b1;
  assign bus.busy      = (r_state == RWAIT);
  assign bus.call_ack  = r_call_ack;
  assign bus.ret_valid = r_ret_valid;
  assign bus.ret_addr  = r_ret_addr;
  assign bus.depth     = r_cnt;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.ovf       = r_ovf;
  assign bus.udf       = r_udf;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_call_ack  <= 1'b0;
      r_ret_valid <= 1'b0;
      r_ret_addr  <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_call_ack  <= 1'b0;
      r_ret_valid <= 1'b0;
      // A flag being set in this cycle takes priority over err_clr.
      r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr);
      r_udf <= w_udf_set | (r_udf & ~bus.err_clr);

      if (bus.flush) begin
        r_cnt   <= '0;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.call) begin
              if (!w_full) begin
                r_cnt <= r_cnt + 1'b1;
              end
              r_call_ack <= 1'b1;
            end else if (bus.ret) begin
              if (!w_empty) begin
                r_state <= RWAIT;
              end else begin
                r_ret_valid <= 1'b1;
                r_ret_addr  <= '0;
              end
            end
          end
          RWAIT: begin
            r_ret_addr  <= bus.stko;
            r_cnt       <= w_cnt_m1;
            r_ret_valid <= 1'b1;
            r_state     <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stk_ctl.sv
// Randomized and directed bench for stk_ctl with a queue-based stack model and
// a behavioural copy of the 4-entry storage beside the DUT.
module tb_stk_ctl;
  import stk_pkg::*;

  logic Clk;
  logic Rst;

  stk_ctl_if u_if();

  stk_ctl u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (u_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Storage: write on push, registered read of the slot under sp.
  logic [AW-1:0] mem [DEPTH];
  always @(posedge Clk) begin
    if (u_if.push) mem[u_if.sp] <= u_if.pcx;
    u_if.stko <= mem[u_if.sp];
  end

  int n_tests;
  int n_fail;

  // Reference model state
  int unsigned m_stk[$];
  bit          m_pend;
  bit          m_ovf;
  bit          m_udf;
  int unsigned m_ra;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input bit exp_ack, input bit exp_rv);
    chk("call_ack", u_if.call_ack, exp_ack);
    chk("ret_valid", u_if.ret_valid, exp_rv);
    chk("ret_addr", u_if.ret_addr, m_ra);
    chk("depth", u_if.depth, m_stk.size());
    chk("full", u_if.full, m_stk.size() == DEPTH);
    chk("empty", u_if.empty, m_stk.size() == 0);
    chk("busy", u_if.busy, m_pend);
    chk("ovf", u_if.ovf, m_ovf);
    chk("udf", u_if.udf, m_udf);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    u_if.call = 1'b0; u_if.ret = 1'b0; u_if.flush = 1'b0; u_if.err_clr = 1'b0;
    u_if.pc = '0;
    @(posedge Clk); #1;
    m_stk.delete(); m_pend = 0; m_ovf = 0; m_udf = 0; m_ra = 0;
    chk("rst_push", u_if.push, 0);
    chk_regs(0, 0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("rst_push_after", u_if.push, 0);
    $display("[TB] reset depth=%0d empty=%0b", u_if.depth, u_if.empty);
  endtask

  task automatic step(input bit c, input bit r, input bit f, input bit e, input int unsigned p);
    bit exp_push;
    bit exp_ack;
    bit exp_rv;
    int unsigned nxt;
    @(negedge Clk);
    u_if.call = c; u_if.ret = r; u_if.flush = f; u_if.err_clr = e;
    u_if.pc = AW'(p);
    #1;
    nxt = (p + 1) & 32'hFFF;
    exp_push = !m_pend && c && !f && (m_stk.size() < DEPTH);
    chk("push", u_if.push, exp_push);
    chk("pcx", u_if.pcx, nxt);
    if (exp_push)
      chk("sp_wr", u_if.sp, m_stk.size());
    else if (!m_pend && !f && !c && r && m_stk.size() > 0)
      chk("sp_rd", u_if.sp, m_stk.size() - 1);

    @(posedge Clk); #1;
    exp_ack = 0;
    exp_rv  = 0;
    if (e) begin
      m_ovf = 0;
      m_udf = 0;
    end
    if (f) begin
      m_stk.delete();
      m_pend = 0;
    end else if (m_pend) begin
      m_ra   = m_stk.pop_back();
      exp_rv = 1;
      m_pend = 0;
    end else if (c) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
      else m_ovf = 1;
      exp_ack = 1;
    end else if (r) begin
      if (m_stk.size() > 0) begin
        m_pend = 1;
      end else begin
        m_udf  = 1;
        exp_rv = 1;
        m_ra   = 0;
      end
    end
    chk_regs(exp_ack, exp_rv);
    $display("[TB] call=%0b ret=%0b flush=%0b clr=%0b pc=%03h | ack=%0b rv=%0b ra=%03h depth=%0d ovf=%0b udf=%0b",
             c, r, f, e, p & 32'hFFF, u_if.call_ack, u_if.ret_valid, u_if.ret_addr,
             u_if.depth, u_if.ovf, u_if.udf);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    Rst = 1'b1;
    u_if.call = 1'b0; u_if.ret = 1'b0; u_if.flush = 1'b0; u_if.err_clr = 1'b0;
    u_if.pc = '0;
    repeat (2) @(posedge Clk);
    do_reset();

    // First CALL: write slot 0 with pc+1
    step(1, 0, 0, 0, 'h100);

    // Four CALLs then four RETs, each RET followed by its RWAIT cycle
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 'h10 * i);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end

    // Overflow on the fifth CALL, then clear
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 'h200 + i);
    step(0, 0, 0, 1, 0);

    // Underflow on RET from empty
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // CALL wins over RET; wraparound of pc+1
    step(1, 0, 0, 0, 'h300);
    step(1, 1, 0, 0, 'h310);
    step(1, 0, 0, 0, 'hFFF);

    // Flush aborts RWAIT, then CALL writes slot 0
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 'h400);

    // Reset during RWAIT
    step(1, 0, 0, 0, 'h500);
    step(0, 1, 0, 0, 0);
    do_reset();

    // Set and clear in the same cycle: set wins
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 'h600 + i);
    step(1, 0, 0, 1, 'h700);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 8,
           $urandom_range(0, 4095));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
